// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write-port controller.
package regfile_ctrl_pkg;

  localparam int unsigned NUM_REGS   = 32;
  localparam int unsigned LL_DAT_W   = 32;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t              rd;
    logic [LL_DAT_W-1:0]   data;
  } ll_entry_t;

  function automatic logic is_x0(input reg_idx_t idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/ll_result_fifo.sv
// Synchronous FIFO holding long-latency results until they win the write port.
module ll_result_fifo
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned Depth   = 2,
  parameter type         entry_t = ll_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output logic   full,
  output logic   empty,
  output entry_t head
);

  localparam int unsigned PtrW = $clog2(Depth);

  entry_t           mem_q [Depth];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic             push_en, pop_en;

  // Extra pointer bit distinguishes full from empty when indices match.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
               (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    push_en  = push && !full;
    pop_en   = pop && !empty;
    wr_ptr_d = push_en ? wr_ptr_q + {{PtrW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = pop_en  ? rd_ptr_q + {{PtrW{1'b0}}, 1'b1} : rd_ptr_q;
    head     = mem_q[rd_ptr_q[PtrW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Shares the register-file write port between WB and a long-latency result queue,
// keeps a busy scoreboard for pending LL writes and throttles WB when the queue starves.
module regfile_write_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int unsigned DAT_WIDTH    = 32,
  parameter int unsigned LL_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_rd,
  input  logic [DAT_WIDTH-1:0] wb_data,
  input  logic                 ll_valid,
  output logic                 ll_ready,
  input  logic [4:0]           ll_rd,
  input  logic [DAT_WIDTH-1:0] ll_data,
  input  logic                 iss_valid,
  input  logic [4:0]           iss_rd,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [4:0]           dec_rd,
  output logic                 hazard,
  output logic                 stall_req,
  output logic                 rf_we,
  output logic [4:0]           rf_rd,
  output logic [DAT_WIDTH-1:0] rf_wdata
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    reg_idx_t             rd;
    logic [DAT_WIDTH-1:0] data;
  } entry_t;

  entry_t                fifo_wdata, fifo_head;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  stall_q, stall_d;

  ll_result_fifo #(
    .Depth   (LL_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (fifo_wdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    ll_ready        = rst_n && !fifo_full;
    push            = ll_valid && ll_ready;
    fifo_wdata.rd   = ll_rd;
    fifo_wdata.data = ll_data;
    pop             = !wb_valid && !fifo_empty;

    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;
    if (wb_valid) begin
      rf_we    = !is_x0(wb_rd);
      rf_rd    = wb_rd;
      rf_wdata = wb_data;
    end else if (!fifo_empty) begin
      rf_we    = !is_x0(fifo_head.rd);
      rf_rd    = fifo_head.rd;
      rf_wdata = fifo_head.data;
    end
  end

  // Set is applied after clear so a same-cycle issue to the retiring rd stays busy.
  always_comb begin
    busy_d = busy_q;
    if (pop) begin
      busy_d[fifo_head.rd] = 1'b0;
    end
    if (iss_valid && !is_x0(iss_rd)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign hazard = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];

  always_comb begin
    cnt_d   = cnt_q;
    stall_d = 1'b0;
    if (fifo_empty || pop) begin
      cnt_d = '0;
    end else begin
      if (cnt_q != CntW'(STARVE_LIMIT)) begin
        cnt_d = cnt_q + 1'b1;
      end
      stall_d = (cnt_q == CntW'(STARVE_LIMIT - 1));
    end
  end

  assign stall_req = stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= '0;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

endmodule
